vs_dma: RTL
===========

VS_DMA -- requirements
Module: vs_dma

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning read-to-write data buffer depth in words (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 16, meaning transfer length counter width in words.
REQ-003 SHALL have parameter SIGNATURE, default 32'h0000D3A0, meaning ID register value.
REQ-004 SHALL have port sys_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port groups wbm_0_* (read master) and wbm_1_* (write master), with adr_o 28, dat_o 32, dat_i 32, sel_o 4, and we_o, stb_o, cyc_o, ack_i, stall_i, err_i 1 each (pipelined Wishbone, word addressed).
REQ-007 SHALL have slave ports wbs_adr in 18, wbs_dat_w in 32, wbs_dat_r out 32, wbs_sel in 4, and wbs_cyc, wbs_stb, wbs_we in 1, and wbs_ack, wbs_stall, wbs_err out 1.
REQ-008 SHALL have port irq_in, input, 32, unused, and port irq_out, output, 1, meaning the level interrupt.

Function
REQ-009 Slave SHALL assert wbs_ack one cycle after wbs_cyc&wbs_stb, with wbs_stall=0 and wbs_err=0 always.
REQ-010 Register map on wbs_adr[2:0]: 0 ID (RO SIGNATURE); 1 CTRL (b0 start W1S self-clearing, b1 irq_en RW, b2 abort W1S self-clearing); 2 STATUS (b0 busy RO, b1 done W1C, b2 err W1C); 3 SRC[27:0]; 4 DST[27:0]; 5 LEN[LEN_W-1:0]; 6-7 read 0, writes ignored.
REQ-011 wbs_dat_r SHALL be registered, valid with wbs_ack; wbs_sel ignored.
REQ-012 FSM states SHALL be IDLE, RUN, FINISH.
REQ-013 IDLE + start with LEN!=0 SHALL latch SRC/DST/LEN into working counters and enter RUN.
REQ-014 IDLE + start with LEN==0 SHALL enter FINISH directly, with no bus cycles.
REQ-015 In RUN, wbm_0 SHALL hold cyc_o=1, we_o=0, sel_o=4'hF, and assert stb_o while reads_issued<LEN and fifo_count+outstanding_reads<FIFO_DEPTH.
REQ-016 wbm_0_adr_o SHALL increment by 1 on each cycle with stb_o&!stall_i.
REQ-017 Each wbm_0_ack_i SHALL push wbm_0_dat_i into the FIFO.
REQ-018 In RUN, wbm_1 SHALL hold cyc_o=1, we_o=1, sel_o=4'hF, and assert stb_o with dat_o=FIFO head while the FIFO is non-empty.
REQ-019 The FIFO SHALL pop on stb_o&!stall_i, and wbm_1_adr_o SHALL increment on the same condition.
REQ-020 wbm_1_cyc_o SHALL stay high until write acks equal LEN.
REQ-021 When write acks equal LEN, RUN SHALL go to FINISH; FINISH SHALL set done=1 and go to IDLE after one cycle.
REQ-022 wbm_0_cyc_o SHALL drop once read acks equal LEN, even if writes remain.
REQ-023 err_i on either master in RUN SHALL drop both cyc_o the next cycle, flush the FIFO, set err=1, leave done unchanged, and go to IDLE.
REQ-024 abort in RUN SHALL do the same as REQ-023 without setting err.
REQ-025 abort in IDLE SHALL have no effect.
REQ-026 start while busy SHALL be ignored.
REQ-027 Writes to SRC/DST/LEN while busy SHALL be ignored.
REQ-028 busy SHALL be 1 exactly in RUN and FINISH.
REQ-029 irq_out SHALL be registered and equal irq_en&(done|err).
REQ-030 If a same-cycle W1C write and a set event coincide, set SHALL win.
REQ-031 Counters SHALL be LEN_W+1 bits; addresses SHALL wrap modulo 2^28.
REQ-032 stb_o SHALL be 0 whenever cyc_o is 0.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, all cyc_o/stb_o/we_o=0, adr_o/dat_o/sel_o=0, and FIFO empty.
REQ-034 rst_n=0 SHALL clear CTRL, STATUS, SRC, DST, and LEN to 0, and set wbs_ack=0 and irq_out=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no further bus activity and no flags set.

Structure
REQ-036 Package vs_dma_pkg SHALL hold register offsets, CTRL/STATUS bit indices, the state enum, and the default signature.
REQ-037 Sub-module vs_dma_fifo SHALL be a synchronous FIFO with parameters FIFO_DEPTH and width 32, and ports push/pop/flush/empty/full/count.

Verification
REQ-038 Scenario: ID read -> wbs_dat_r=32'h0000D3A0, ack 1 cycle after stb.
REQ-039 Scenario: SRC=0x100, DST=0x200, LEN=20, start, zero-stall memories -> 20 writes at 0x200..0x213 with data from 0x100..0x113, done=1, irq_out=1 with irq_en.
REQ-040 Scenario: LEN=20 with write-side stall 3 of 4 cycles -> fifo_count+outstanding never exceeds 8, data intact.
REQ-041 Scenario: wbm_0_err_i on read 5 -> both cyc_o low next cycle, err=1, done=0, busy=0.
REQ-042 Scenario: LEN=0 start -> no stb_o ever, done=1 two cycles after the start write.
REQ-043 Scenario: abort at write 10, then rst_n low mid-second transfer -> bus idle, STATUS=0.

Source files
------------

// File: rtl/vs_dma_pkg.sv
// rtl/vs_dma_pkg.sv - shared register map, bit indices and FSM state type for vs_dma
package vs_dma_pkg;

    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_SRC    = 3'd3;
    localparam logic [2:0] REG_DST    = 3'd4;
    localparam logic [2:0] REG_LEN    = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [31:0] DEFAULT_SIGNATURE = 32'h0000D3A0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/vs_dma_fifo.sv
// rtl/vs_dma_fifo.sv - synchronous FIFO buffering read data for the write master
module vs_dma_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign empty    = (r_count == '0);
    assign full     = (r_count == DEPTH_C);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // storage array, written on accepted push (not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vs_dma.sv
// rtl/vs_dma.sv - memory-to-memory DMA with pipelined Wishbone read/write masters
module vs_dma
    import vs_dma_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          LEN_W      = 16,
    parameter logic [31:0] SIGNATURE  = DEFAULT_SIGNATURE
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    output logic [27:0] wbm_0_adr_o,
    output logic [31:0] wbm_0_dat_o,
    input  logic [31:0] wbm_0_dat_i,
    output logic [3:0]  wbm_0_sel_o,
    output logic        wbm_0_we_o,
    output logic        wbm_0_stb_o,
    output logic        wbm_0_cyc_o,
    input  logic        wbm_0_ack_i,
    input  logic        wbm_0_stall_i,
    input  logic        wbm_0_err_i,
    output logic [27:0] wbm_1_adr_o,
    output logic [31:0] wbm_1_dat_o,
    input  logic [31:0] wbm_1_dat_i,
    output logic [3:0]  wbm_1_sel_o,
    output logic        wbm_1_we_o,
    output logic        wbm_1_stb_o,
    output logic        wbm_1_cyc_o,
    input  logic        wbm_1_ack_i,
    input  logic        wbm_1_stall_i,
    input  logic        wbm_1_err_i,
    input  logic [17:0] wbs_adr,
    input  logic [31:0] wbs_dat_w,
    output logic [31:0] wbs_dat_r,
    input  logic [3:0]  wbs_sel,
    input  logic        wbs_cyc,
    input  logic        wbs_stb,
    input  logic        wbs_we,
    output logic        wbs_ack,
    output logic        wbs_stall,
    output logic        wbs_err,
    input  logic [31:0] irq_in,
    output logic        irq_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W:0] DEPTH_C = (LEN_W+1)'(FIFO_DEPTH);

    state_t             r_state, w_state_nxt;
    logic               r_ack, r_irq, r_irq_en, r_done, r_err;
    logic [31:0]        r_dat_r, w_rd_mux;
    logic [27:0]        r_src, r_dst, r_rd_adr, r_wr_adr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W:0]     r_cnt_len, r_rd_iss, r_rd_ack, r_wr_ack, w_occ;
    logic               w_req, w_wr, w_start, w_abort, w_busy, w_stat_wr;
    logic               w_rd_cyc, w_rd_stb, w_wr_cyc, w_wr_stb;
    logic               w_rd_take, w_rd_ackd, w_wr_take, w_wr_ackd;
    logic               w_bus_err, w_kill, w_last_wr;
    logic [31:0]        w_fifo_head;
    logic               w_fifo_empty, w_fifo_full;
    logic [AW:0]        w_fifo_count;
    logic               w_unused;

    assign w_unused  = ^{irq_in, wbs_sel, wbs_adr[17:3], wbm_1_dat_i, wbs_dat_w[31:28], w_fifo_full};

    // register-port decode
    assign w_req     = wbs_cyc & wbs_stb;
    assign w_wr      = w_req & wbs_we;
    assign w_start   = w_wr && (wbs_adr[2:0] == REG_CTRL) && wbs_dat_w[CTRL_START];
    assign w_abort   = w_wr && (wbs_adr[2:0] == REG_CTRL) && wbs_dat_w[CTRL_ABORT];
    assign w_stat_wr = w_wr && (wbs_adr[2:0] == REG_STATUS);
    assign w_busy    = (r_state != IDLE);

    // read master issues only while buffer space covers every read in flight
    assign w_occ     = (LEN_W+1)'(w_fifo_count) + (r_rd_iss - r_rd_ack);
    assign w_rd_cyc  = (r_state == RUN) && (r_rd_ack != r_cnt_len);
    assign w_rd_stb  = w_rd_cyc && (r_rd_iss < r_cnt_len) && (w_occ < DEPTH_C);
    assign w_wr_cyc  = (r_state == RUN);
    assign w_wr_stb  = w_wr_cyc && !w_fifo_empty;
    assign w_rd_take = w_rd_stb & ~wbm_0_stall_i;
    assign w_wr_take = w_wr_stb & ~wbm_1_stall_i;
    assign w_rd_ackd = w_rd_cyc & wbm_0_ack_i;
    assign w_wr_ackd = w_wr_cyc & wbm_1_ack_i;
    assign w_bus_err = (w_rd_cyc & wbm_0_err_i) | (w_wr_cyc & wbm_1_err_i);
    assign w_kill    = (r_state == RUN) && (w_bus_err || w_abort);
    assign w_last_wr = w_wr_ackd && ((r_wr_ack + 1'b1) == r_cnt_len);

    assign wbm_0_cyc_o = w_rd_cyc;
    assign wbm_0_stb_o = w_rd_stb;
    assign wbm_0_we_o  = 1'b0;
    assign wbm_0_sel_o = w_rd_cyc ? 4'hF : 4'h0;
    assign wbm_0_adr_o = r_rd_adr;
    assign wbm_0_dat_o = '0;
    assign wbm_1_cyc_o = w_wr_cyc;
    assign wbm_1_stb_o = w_wr_stb;
    assign wbm_1_we_o  = w_wr_cyc;
    assign wbm_1_sel_o = w_wr_cyc ? 4'hF : 4'h0;
    assign wbm_1_adr_o = r_wr_adr;
    assign wbm_1_dat_o = w_wr_stb ? w_fifo_head : '0;

    assign wbs_dat_r = r_dat_r;
    assign wbs_ack   = r_ack;
    assign wbs_stall = 1'b0;
    assign wbs_err   = 1'b0;
    assign irq_out   = r_irq;

    vs_dma_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (w_rd_ackd),
        .push_data (wbm_0_dat_i),
        .pop       (w_wr_take),
        .flush     (w_kill),
        .pop_data  (w_fifo_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: zero-length start skips straight to FINISH
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = (r_len == '0) ? FINISH : RUN;
            RUN:     if (w_kill) w_state_nxt = IDLE;
                     else if (w_last_wr) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // working address/counter registers for the active transfer
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_rd_adr  <= '0;
            r_wr_adr  <= '0;
            r_cnt_len <= '0;
            r_rd_iss  <= '0;
            r_rd_ack  <= '0;
            r_wr_ack  <= '0;
        end else if ((r_state == IDLE) && w_start) begin
            r_rd_adr  <= r_src;
            r_wr_adr  <= r_dst;
            r_cnt_len <= {1'b0, r_len};
            r_rd_iss  <= '0;
            r_rd_ack  <= '0;
            r_wr_ack  <= '0;
        end else if (r_state == RUN) begin
            if (w_rd_take) begin
                r_rd_adr <= r_rd_adr + 1'b1;
                r_rd_iss <= r_rd_iss + 1'b1;
            end
            if (w_rd_ackd) r_rd_ack <= r_rd_ack + 1'b1;
            if (w_wr_take) r_wr_adr <= r_wr_adr + 1'b1;
            if (w_wr_ackd) r_wr_ack <= r_wr_ack + 1'b1;
        end
    end

    // register read mux
    always_comb begin
        w_rd_mux = '0;
        case (wbs_adr[2:0])
            REG_ID:     w_rd_mux = SIGNATURE;
            REG_CTRL:   w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            REG_STATUS: begin
                w_rd_mux[STAT_BUSY] = w_busy;
                w_rd_mux[STAT_DONE] = r_done;
                w_rd_mux[STAT_ERR]  = r_err;
            end
            REG_SRC:    w_rd_mux[27:0] = r_src;
            REG_DST:    w_rd_mux[27:0] = r_dst;
            REG_LEN:    w_rd_mux[LEN_W-1:0] = r_len;
            default:    w_rd_mux = '0;
        endcase
    end

    // register file, slave ack/data and interrupt; status set events beat W1C clears
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_ack    <= 1'b0;
            r_dat_r  <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat_r <= w_rd_mux;
            if (w_wr && !w_busy) begin
                case (wbs_adr[2:0])
                    REG_SRC: r_src <= wbs_dat_w[27:0];
                    REG_DST: r_dst <= wbs_dat_w[27:0];
                    REG_LEN: r_len <= wbs_dat_w[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (w_wr && (wbs_adr[2:0] == REG_CTRL)) r_irq_en <= wbs_dat_w[CTRL_IRQ_EN];
            if (r_state == FINISH)                          r_done <= 1'b1;
            else if (w_stat_wr && wbs_dat_w[STAT_DONE])     r_done <= 1'b0;
            if ((r_state == RUN) && w_bus_err)              r_err  <= 1'b1;
            else if (w_stat_wr && wbs_dat_w[STAT_ERR])      r_err  <= 1'b0;
            r_irq <= r_irq_en & (r_done | r_err);
        end
    end

endmodule
